key_step_gen: RTL and testbench
===============================

KEY_STEP_GEN -- requirements
Module: key_step_gen

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 8, meaning consecutive sampled cycles a key level must hold to be accepted (minimum 1).
REQ-002 The block SHALL have parameter REP_DELAY, default 32, meaning cycles from the first step to the first auto-repeat step (minimum 1).
REQ-003 The block SHALL have parameter REP_RATE, default 8, meaning cycles between successive auto-repeat steps (minimum 1).
REQ-004 The block SHALL have parameter REP_EN, default 1, meaning auto-repeat enable (0 = one step per press).
REQ-005 The block SHALL have parameter CNT_W, default 16, meaning the internal counter width; it must hold max(DEB_CYCLES, REP_DELAY, REP_RATE).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port key_n, input, 1 bit: raw pushbutton, asynchronous, active-low (0 = pressed).
REQ-009 The block SHALL have port dir_sw, input, 1 bit: raw direction switch, asynchronous (1 = up).
REQ-010 The block SHALL have port step, output, 1 bit: a one-cycle count-enable pulse to the downstream up/down counter.
REQ-011 The block SHALL have port up, output, 1 bit: registered direction, valid whenever step is high.
REQ-012 The block SHALL have port pressed, output, 1 bit: the debounced key level (1 = held).

Function
REQ-013 key_n and dir_sw SHALL each pass through a 2-flop synchronizer; key_n flops reset to 1, dir_sw flops reset to 0; k = inverted synchronized key_n.
REQ-014 The FSM SHALL have the states IDLE, PRESS_DEB, HOLD, REPEAT and REL_DEB, plus one counter cnt of CNT_W bits.
REQ-015 In IDLE, k=1 SHALL move the FSM to PRESS_DEB with cnt=0; otherwise the FSM stays in IDLE.
REQ-016 In PRESS_DEB, k=0 SHALL return the FSM to IDLE with no step (bounce rejected).
REQ-017 In PRESS_DEB, k=1 with cnt<DEB_CYCLES-1 SHALL increment cnt.
REQ-018 In PRESS_DEB, k=1 with cnt=DEB_CYCLES-1 SHALL move the FSM to HOLD, clear cnt, set pressed=1 and emit one step.
REQ-019 In HOLD, k=0 SHALL move the FSM to REL_DEB with cnt=0.
REQ-020 In HOLD, with k=1 and REP_EN=1, cnt SHALL count up; at cnt=REP_DELAY-1 the FSM moves to REPEAT, clears cnt and emits a step.
REQ-021 In HOLD, with REP_EN=0, cnt SHALL hold at 0 and no further steps are emitted.
REQ-022 In REPEAT, k=0 SHALL move the FSM to REL_DEB with cnt=0.
REQ-023 In REPEAT, with k=1, cnt SHALL count up; at cnt=REP_RATE-1 a step is emitted and cnt is cleared, and this repeats indefinitely.
REQ-024 In REL_DEB, k=1 SHALL return the FSM to HOLD with cnt=0 and no step (release bounce never produces a step).
REQ-025 In REL_DEB, k=0 with cnt=DEB_CYCLES-1 SHALL move the FSM to IDLE and clear pressed; otherwise cnt increments.
REQ-026 step SHALL be a registered output, high for exactly one cycle per emission and never high in two consecutive cycles.
REQ-027 up SHALL be loaded from synchronized dir_sw on the same edge that sets step, and hold its value between steps.
REQ-028 Latency: with key_n low and stable and the first sampling edge counted as edge 1, step SHALL be high after edge DEB_CYCLES+3; later steps follow at +REP_DELAY, then every +REP_RATE.
REQ-029 cnt SHALL never wrap; each state clears it on exit.

Reset
REQ-030 When rst=1, the block SHALL asynchronously force state=IDLE, cnt=0, step=0, up=0, pressed=0 and reset the synchronizers.
REQ-031 Release of rst SHALL be followed by normal operation from the next rising edge; a key already held at release is treated as a new press (full debounce, then a step).

Verification (defaults DEB_CYCLES=8, REP_DELAY=32, REP_RATE=8)
REQ-032 The bench SHALL cover power-on: assert rst for 3 cycles -> step=0, up=0, pressed=0 throughout and after release with key_n=1.
REQ-033 The bench SHALL cover a clean press held 20 cycles, then released: step high only after edge 11, pressed rises at edge 11, and pressed falls 10 edges after key_n returns high.
REQ-034 The bench SHALL cover bounce: key_n low 5 cycles, high 2, low 5, high -> no step and pressed stays 0.
REQ-035 The bench SHALL cover auto-repeat: key_n held low 60 cycles -> steps after edges 11, 43, 51 and 59 only; with REP_EN=0 -> a single step after edge 11.
REQ-036 The bench SHALL cover direction: dir_sw=1 then set to 0 mid-hold before the repeat -> up=1 at the first step and up=0 at the repeat steps.
REQ-037 The bench SHALL cover reset mid-operation: assert rst while in REPEAT -> outputs 0 at once; release with key_n still low -> next step after edge 11 from release.

Source files
------------

// File: rtl/key_step_gen.sv
// Debounced pushbutton to up/down count-step generator with optional auto-repeat.
// Raw key and direction inputs are synchronized; step is a registered one-cycle pulse.
module key_step_gen #(
  parameter int unsigned DEB_CYCLES = 8,
  parameter int unsigned REP_DELAY  = 32,
  parameter int unsigned REP_RATE   = 8,
  parameter int unsigned REP_EN     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic dir_sw,
  output logic step,
  output logic up,
  output logic pressed
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPressDeb = 3'd1;
  localparam logic [2:0] StHold     = 3'd2;
  localparam logic [2:0] StRepeat   = 3'd3;
  localparam logic [2:0] StRelDeb   = 3'd4;

  localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REP_RATE - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic             key_s1_q, key_s2_q;
  logic             dir_s1_q, dir_s2_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             up_q, up_d;
  logic             pressed_q, pressed_d;
  logic             k;

  // Key synchronizer idles released (1); direction idles down (0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      dir_s1_q <= 1'b0;
      dir_s2_q <= 1'b0;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      dir_s1_q <= dir_sw;
      dir_s2_q <= dir_s1_q;
    end
  end

  assign k = ~key_s2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = 1'b0;
    up_d      = up_q;
    pressed_d = pressed_q;
    case (state_q)
      StIdle: begin
        if (k) begin
          state_d = StPressDeb;
          cnt_d   = '0;
        end
      end
      StPressDeb: begin
        if (!k) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StHold;
          cnt_d     = '0;
          pressed_d = 1'b1;
          step_d    = 1'b1;
          up_d      = dir_s2_q;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHold: begin
        if (!k) begin
          state_d = StRelDeb;
          cnt_d   = '0;
        end else if (REP_EN != 0) begin
          if (cnt_q == DelayLast) begin
            state_d = StRepeat;
            cnt_d   = '0;
            step_d  = 1'b1;
            up_d    = dir_s2_q;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          cnt_d = '0;
        end
      end
      StRepeat: begin
        if (!k) begin
          state_d = StRelDeb;
          cnt_d   = '0;
        end else if (cnt_q == RateLast) begin
          cnt_d  = '0;
          step_d = 1'b1;
          up_d   = dir_s2_q;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRelDeb: begin
        // A key seen again during release debounce resumes holding, restarting the repeat delay.
        if (k) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      up_q      <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      up_q      <= up_d;
      pressed_q <= pressed_d;
    end
  end

  assign step    = step_q;
  assign up      = up_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_key_step_gen.sv
// Bench for key_step_gen: a repeating instance and a one-shot instance share the same stimulus
// and are checked every cycle against a run-length model plus fixed edge expectations.
module tb_key_step_gen;

  localparam int DEB  = 8;
  localparam int DLY  = 32;
  localparam int RATE = 8;

  logic clk = 1'b0;
  logic rst, key_n, dir_sw;
  logic step_a, up_a, pressed_a;
  logic step_b, up_b, pressed_b;

  int total = 0;
  int bad   = 0;
  int edge_no;

  // Model: input synchronizer delay, then run lengths of the seen key level.
  bit m_ks1, m_ks2, m_ds1, m_ds2;
  int m_run[2], m_zrun[2], m_since[2];
  bit m_rep[2], m_pressed[2], m_step[2], m_up[2];

  int step_edges_a[$], step_edges_b[$];
  bit step_up_a[$];
  int rise_edge, fall_edge;
  bit prev_pressed;

  always #5 clk = ~clk;

  key_step_gen #(.DEB_CYCLES(DEB), .REP_DELAY(DLY), .REP_RATE(RATE), .REP_EN(1), .CNT_W(16))
    u_dut_rep (.clk(clk), .rst(rst), .key_n(key_n), .dir_sw(dir_sw),
               .step(step_a), .up(up_a), .pressed(pressed_a));

  key_step_gen #(.DEB_CYCLES(DEB), .REP_DELAY(DLY), .REP_RATE(RATE), .REP_EN(0), .CNT_W(16))
    u_dut_norep (.clk(clk), .rst(rst), .key_n(key_n), .dir_sw(dir_sw),
                 .step(step_b), .up(up_b), .pressed(pressed_b));

  task automatic model_reset();
    m_ks1 = 1'b1; m_ks2 = 1'b1; m_ds1 = 1'b0; m_ds2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_zrun[i] = 0; m_since[i] = 0;
      m_rep[i] = 1'b0; m_pressed[i] = 1'b0; m_step[i] = 1'b0; m_up[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit k, d;
    k = !m_ks2;
    d = m_ds2;
    for (int i = 0; i < 2; i++) begin
      m_step[i] = 1'b0;
      if (!m_pressed[i]) begin
        if (k) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_pressed[i] = 1'b1; m_step[i] = 1'b1; m_up[i] = d;
            m_run[i] = 0; m_since[i] = 0; m_rep[i] = 1'b0; m_zrun[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end else if (!k) begin
        m_zrun[i]++;
        if (m_zrun[i] == DEB + 1) begin
          m_pressed[i] = 1'b0; m_zrun[i] = 0; m_run[i] = 0;
        end
      end else if (m_zrun[i] > 0) begin
        m_zrun[i] = 0; m_since[i] = 0; m_rep[i] = 1'b0;
      end else if (i == 0) begin
        m_since[i]++;
        if ((!m_rep[i] && m_since[i] == DLY) || (m_rep[i] && m_since[i] == RATE)) begin
          m_step[i] = 1'b1; m_up[i] = d; m_since[i] = 0; m_rep[i] = 1'b1;
        end
      end
    end
    m_ks2 = m_ks1; m_ks1 = key_n;
    m_ds2 = m_ds1; m_ds1 = dir_sw;
  endtask

  // One clock: drive inputs, advance model at the edge, sample the DUTs on the falling edge.
  task automatic tick(input bit kn, input bit ds);
    key_n  = kn;
    dir_sw = ds;
    @(posedge clk);
    edge_no++;
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    if (step_a === 1'b1) begin
      step_edges_a.push_back(edge_no);
      step_up_a.push_back(up_a);
    end
    if (step_b === 1'b1) step_edges_b.push_back(edge_no);
    if (pressed_a === 1'b1 && !prev_pressed) rise_edge = edge_no;
    if (pressed_a === 1'b0 && prev_pressed) fall_edge = edge_no;
    prev_pressed = (pressed_a === 1'b1);
  endtask

  task automatic start_test();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    edge_no = 0;
    step_edges_a.delete();
    step_edges_b.delete();
    step_up_a.delete();
    rise_edge = -1;
    fall_edge = -1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      total++;
      if ({step_a, up_a, pressed_a, step_b, up_b, pressed_b} !== 6'b0) begin
        bad++;
        $display("FAIL reset_hold cyc %0d: got %b want 000000", i,
                 {step_a, up_a, pressed_a, step_b, up_b, pressed_b});
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      total++;
      if ({step_a, up_a, pressed_a, step_b, up_b, pressed_b} !== 6'b0) begin
        bad++;
        $display("FAIL reset_release cyc %0d: got %b want 000000", i,
                 {step_a, up_a, pressed_a, step_b, up_b, pressed_b});
      end
    end
  endtask

  task automatic test_clean_press();
    start_test();
    for (int i = 0; i < 40; i++) begin
      tick((i < 20) ? 1'b0 : 1'b1, 1'b1);
      total++;
      if ({step_a, up_a, pressed_a, step_b, up_b, pressed_b} !==
          {m_step[0], m_up[0], m_pressed[0], m_step[1], m_up[1], m_pressed[1]}) begin
        bad++;
        $display("FAIL clean_press edge %0d: got %b want %b", edge_no,
                 {step_a, up_a, pressed_a, step_b, up_b, pressed_b},
                 {m_step[0], m_up[0], m_pressed[0], m_step[1], m_up[1], m_pressed[1]});
      end
    end
    total++;
    if (step_edges_a.size() != 1 || step_edges_a[0] != 11) begin
      bad++;
      $display("FAIL clean_press_step_edges: got %p want '{11}", step_edges_a);
    end
    total++;
    if (rise_edge != 11) begin
      bad++;
      $display("FAIL clean_press_rise: got edge %0d want 11", rise_edge);
    end
    total++;
    if (fall_edge != 31) begin
      bad++;
      $display("FAIL clean_press_fall: got edge %0d want 31", fall_edge);
    end
  endtask

  task automatic test_bounce();
    start_test();
    for (int i = 0; i < 30; i++) begin
      tick((i < 5 || (i >= 7 && i < 12)) ? 1'b0 : 1'b1, 1'b0);
      total++;
      if ({step_a, pressed_a, step_b, pressed_b} !== 4'b0) begin
        bad++;
        $display("FAIL bounce edge %0d: got %b want 0000", edge_no,
                 {step_a, pressed_a, step_b, pressed_b});
      end
    end
    total++;
    if (step_edges_a.size() != 0 || step_edges_b.size() != 0 || rise_edge != -1) begin
      bad++;
      $display("FAIL bounce_summary: got steps %0d/%0d rise %0d want 0/0 -1",
               step_edges_a.size(), step_edges_b.size(), rise_edge);
    end
  endtask

  task automatic test_auto_repeat();
    int exp_a[4];
    exp_a = '{11, 43, 51, 59};
    start_test();
    for (int i = 0; i < 80; i++) begin
      tick((i < 60) ? 1'b0 : 1'b1, 1'b0);
      total++;
      if ({step_a, up_a, pressed_a, step_b, up_b, pressed_b} !==
          {m_step[0], m_up[0], m_pressed[0], m_step[1], m_up[1], m_pressed[1]}) begin
        bad++;
        $display("FAIL auto_repeat edge %0d: got %b want %b", edge_no,
                 {step_a, up_a, pressed_a, step_b, up_b, pressed_b},
                 {m_step[0], m_up[0], m_pressed[0], m_step[1], m_up[1], m_pressed[1]});
      end
    end
    total++;
    if (step_edges_a.size() != 4) begin
      bad++;
      $display("FAIL auto_repeat_count: got %0d steps %p want 4", step_edges_a.size(),
               step_edges_a);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (step_edges_a[i] != exp_a[i]) begin
          bad++;
          $display("FAIL auto_repeat_edge%0d: got %0d want %0d", i, step_edges_a[i], exp_a[i]);
        end
      end
    end
    total++;
    if (step_edges_b.size() != 1 || step_edges_b[0] != 11) begin
      bad++;
      $display("FAIL no_repeat_edges: got %p want '{11}", step_edges_b);
    end
  endtask

  task automatic test_direction();
    start_test();
    for (int i = 0; i < 65; i++) begin
      tick((i < 50) ? 1'b0 : 1'b1, (i < 20) ? 1'b1 : 1'b0);
      total++;
      if ({step_a, up_a, pressed_a, step_b, up_b, pressed_b} !==
          {m_step[0], m_up[0], m_pressed[0], m_step[1], m_up[1], m_pressed[1]}) begin
        bad++;
        $display("FAIL direction edge %0d: got %b want %b", edge_no,
                 {step_a, up_a, pressed_a, step_b, up_b, pressed_b},
                 {m_step[0], m_up[0], m_pressed[0], m_step[1], m_up[1], m_pressed[1]});
      end
    end
    total++;
    if (step_up_a.size() < 2 || step_up_a[0] !== 1'b1) begin
      bad++;
      $display("FAIL direction_first: got %0d steps, up %p want >=2 steps, first up 1",
               step_up_a.size(), step_up_a);
    end else begin
      for (int i = 1; i < step_up_a.size(); i++) begin
        total++;
        if (step_up_a[i] !== 1'b0) begin
          bad++;
          $display("FAIL direction_repeat%0d: got up %b want 0", i, step_up_a[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    start_test();
    for (int i = 0; i < 55; i++) tick(1'b0, 1'b1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    total++;
    if ({step_a, up_a, pressed_a, step_b, up_b, pressed_b} !== 6'b0) begin
      bad++;
      $display("FAIL reset_mid_async: got %b want 000000",
               {step_a, up_a, pressed_a, step_b, up_b, pressed_b});
    end
    @(negedge clk);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    rst = 1'b0;
    edge_no = 0;
    step_edges_a.delete();
    step_edges_b.delete();
    rise_edge = -1;
    prev_pressed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1);
      total++;
      if ({step_a, up_a, pressed_a, step_b, up_b, pressed_b} !==
          {m_step[0], m_up[0], m_pressed[0], m_step[1], m_up[1], m_pressed[1]}) begin
        bad++;
        $display("FAIL reset_mid edge %0d: got %b want %b", edge_no,
                 {step_a, up_a, pressed_a, step_b, up_b, pressed_b},
                 {m_step[0], m_up[0], m_pressed[0], m_step[1], m_up[1], m_pressed[1]});
      end
    end
    total++;
    if (step_edges_a.size() != 1 || step_edges_a[0] != 11 ||
        step_edges_b.size() != 1 || step_edges_b[0] != 11) begin
      bad++;
      $display("FAIL reset_mid_step: got %p / %p want '{11} / '{11}", step_edges_a,
               step_edges_b);
    end
  endtask

  task automatic test_random();
    bit kn, ds;
    int run;
    start_test();
    kn = 1'b1;
    ds = 1'b0;
    run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        kn  = ~kn;
        run = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 80);
        if ($urandom_range(0, 3) == 0) ds = ~ds;
      end
      run--;
      tick(kn, ds);
      total++;
      if ({step_a, up_a, pressed_a, step_b, up_b, pressed_b} !==
          {m_step[0], m_up[0], m_pressed[0], m_step[1], m_up[1], m_pressed[1]}) begin
        bad++;
        $display("FAIL random edge %0d: got %b want %b", edge_no,
                 {step_a, up_a, pressed_a, step_b, up_b, pressed_b},
                 {m_step[0], m_up[0], m_pressed[0], m_step[1], m_up[1], m_pressed[1]});
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    key_n        = 1'b1;
    dir_sw       = 1'b0;
    edge_no      = 0;
    rise_edge    = -1;
    fall_edge    = -1;
    prev_pressed = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_direction();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
